// File: rtl/yuv_rgb_pkg.sv
// Shared types and BT.601 coefficient sets for the YUV->RGB stream converter.
// Coefficients are stored at 16 fractional bits and offsets at 8-bit sample scale;
// the converter rescales them to its FRAC and IN_W parameters.
package yuv_rgb_pkg;

    localparam int unsigned COEF_BASE_W = 18;
    localparam int unsigned OFFS_BASE_W = 8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_Y    = 3'd1,
        S_V    = 3'd2,
        S_U    = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    typedef struct packed {
        logic [COEF_BASE_W-1:0] c_y;
        logic [COEF_BASE_W-1:0] c_rv;
        logic [COEF_BASE_W-1:0] c_gv;
        logic [COEF_BASE_W-1:0] c_gu;
        logic [COEF_BASE_W-1:0] c_bu;
        logic [OFFS_BASE_W-1:0] yoff;
    } coef_set_t;

    // BT.601 limited range (Y 16..235, chroma 16..240)
    localparam coef_set_t COEF_LIMITED = '{
        c_y  : 18'd76284,
        c_rv : 18'd104595,
        c_gv : 18'd53281,
        c_gu : 18'd25624,
        c_bu : 18'd132251,
        yoff : 8'd16
    };

    // BT.601 full range (Y 0..255)
    localparam coef_set_t COEF_FULL = '{
        c_y  : 18'd65536,
        c_rv : 18'd91881,
        c_gv : 18'd46802,
        c_gu : 18'd22554,
        c_bu : 18'd116130,
        yoff : 8'd0
    };

endpackage

// File: rtl/rgb_clip.sv
// Combinational fixed-point to pixel conversion: arithmetic shift by FRAC,
// saturate to [0, 2^IN_W-1], then keep the top OUT_W bits.
//   i_acc    signed accumulator, ACC_W bits
//   o_pix_c  clipped colour component, OUT_W bits
module rgb_clip #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = 8,
    parameter int unsigned FRAC  = 16,
    parameter int unsigned ACC_W = 32
) (
    input  logic signed [ACC_W-1:0] i_acc,
    output logic        [OUT_W-1:0] o_pix_c
);

    localparam logic signed [ACC_W-1:0] LIM = ACC_W'((1 << IN_W) - 1);

    logic signed [ACC_W-1:0] w_p;
    logic        [IN_W-1:0]  w_clip;

    // Arithmetic shift rounds toward -inf
    assign w_p = i_acc >>> FRAC;

    always_comb begin
        w_clip = '0;
        if (w_p[ACC_W-1]) begin
            w_clip = '0;
        end else if (w_p > LIM) begin
            w_clip = '1;
        end else begin
            w_clip = w_p[IN_W-1:0];
        end
    end

    assign o_pix_c = w_clip[IN_W-1 -: OUT_W];

endmodule

// File: rtl/yuv_to_rgb_stream.sv
// YUV->RGB converter with valid/ready on both sides. Each pixel takes three
// arithmetic phases (Y, V, U) sharing two multipliers, then sits in S_HOLD
// until downstream takes it.
//   CLOCK_50_I, resetn          clock, async active-low reset
//   in_valid/in_ready           input handshake; y_in/u_in/v_in/mode payload
//   out_valid/out_ready         output handshake; r_out/g_out/b_out payload
//   busy                        state != S_IDLE
module yuv_to_rgb_stream
    import yuv_rgb_pkg::*;
#(
    parameter int unsigned IN_W   = 8,
    parameter int unsigned OUT_W  = 8,
    parameter int unsigned COEF_W = 18,
    parameter int unsigned FRAC   = 16,
    parameter int unsigned ACC_W  = 32
) (
    input  logic             CLOCK_50_I,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  y_in,
    input  logic [IN_W-1:0]  u_in,
    input  logic [IN_W-1:0]  v_in,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] r_out,
    output logic [OUT_W-1:0] g_out,
    output logic [OUT_W-1:0] b_out,
    output logic             busy
);

    localparam int unsigned DW = IN_W + 1;
    localparam logic [DW-1:0] VO = DW'(128) << (IN_W - 8);

    state_t r_state, w_next;
    logic   w_accept;

    logic [IN_W-1:0] r_y, r_u, r_v;
    logic            r_mode;

    logic signed [ACC_W-1:0] r_acc_r, r_acc_g, r_acc_b;
    logic        [OUT_W-1:0] r_red, r_grn, r_blu;
    logic                    r_out_valid;

    coef_set_t               w_cs;
    logic        [DW-1:0]    w_yoff;
    logic signed [DW-1:0]    w_dy, w_du, w_dv, w_diff;
    logic        [COEF_W-1:0] w_c0, w_c1;
    logic signed [ACC_W-1:0] w_dext, w_m0, w_m1;
    logic signed [ACC_W-1:0] w_g_fin, w_b_fin;
    logic        [OUT_W-1:0] w_r_pix, w_g_pix, w_b_pix;

    // State register
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and input handshake
    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_Y;
                end
            end
            S_Y:    w_next = S_V;
            S_V:    w_next = S_U;
            S_U:    w_next = S_HOLD;
            S_HOLD: begin
                in_ready = out_ready;
                if (out_ready) begin
                    w_accept = in_valid;
                    w_next   = in_valid ? S_Y : S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Coefficient set follows the mode captured with the pixel
    assign w_cs   = r_mode ? COEF_FULL : COEF_LIMITED;
    assign w_yoff = DW'(w_cs.yoff) << (IN_W - 8);

    assign w_dy = $signed({1'b0, r_y}) - $signed(w_yoff);
    assign w_du = $signed({1'b0, r_u}) - $signed(VO);
    assign w_dv = $signed({1'b0, r_v}) - $signed(VO);

    // Phase mux: multiplier 0 feeds R/B (and Y), multiplier 1 feeds the G subtraction
    always_comb begin
        w_diff = w_dy;
        w_c0   = COEF_W'(w_cs.c_y) << (FRAC - 16);
        w_c1   = '0;
        case (r_state)
            S_V: begin
                w_diff = w_dv;
                w_c0   = COEF_W'(w_cs.c_rv) << (FRAC - 16);
                w_c1   = COEF_W'(w_cs.c_gv) << (FRAC - 16);
            end
            S_U: begin
                w_diff = w_du;
                w_c0   = COEF_W'(w_cs.c_bu) << (FRAC - 16);
                w_c1   = COEF_W'(w_cs.c_gu) << (FRAC - 16);
            end
            default: ;
        endcase
    end

    assign w_dext = {{(ACC_W - DW){w_diff[DW-1]}}, w_diff};
    assign w_m0   = w_dext * $signed(ACC_W'(w_c0));
    assign w_m1   = w_dext * $signed(ACC_W'(w_c1));

    // Final G and B include the U-phase products so clipping happens in S_U
    assign w_g_fin = r_acc_g - w_m1;
    assign w_b_fin = r_acc_b + w_m0;

    rgb_clip #(.IN_W(IN_W), .OUT_W(OUT_W), .FRAC(FRAC), .ACC_W(ACC_W)) u_clip_r (
        .i_acc   (r_acc_r),
        .o_pix_c (w_r_pix)
    );
    rgb_clip #(.IN_W(IN_W), .OUT_W(OUT_W), .FRAC(FRAC), .ACC_W(ACC_W)) u_clip_g (
        .i_acc   (w_g_fin),
        .o_pix_c (w_g_pix)
    );
    rgb_clip #(.IN_W(IN_W), .OUT_W(OUT_W), .FRAC(FRAC), .ACC_W(ACC_W)) u_clip_b (
        .i_acc   (w_b_fin),
        .o_pix_c (w_b_pix)
    );

    // Capture, accumulate and output registers
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            r_y         <= '0;
            r_u         <= '0;
            r_v         <= '0;
            r_mode      <= 1'b0;
            r_acc_r     <= '0;
            r_acc_g     <= '0;
            r_acc_b     <= '0;
            r_red       <= '0;
            r_grn       <= '0;
            r_blu       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_y    <= y_in;
                r_u    <= u_in;
                r_v    <= v_in;
                r_mode <= mode;
            end
            case (r_state)
                S_Y: begin
                    r_acc_r <= w_m0;
                    r_acc_g <= w_m0;
                    r_acc_b <= w_m0;
                end
                S_V: begin
                    r_acc_r <= r_acc_r + w_m0;
                    r_acc_g <= r_acc_g - w_m1;
                end
                S_U: begin
                    r_acc_g     <= w_g_fin;
                    r_acc_b     <= w_b_fin;
                    r_red       <= w_r_pix;
                    r_grn       <= w_g_pix;
                    r_blu       <= w_b_pix;
                    r_out_valid <= 1'b1;
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign r_out     = r_red;
    assign g_out     = r_grn;
    assign b_out     = r_blu;
    assign out_valid = r_out_valid;
    assign busy      = (r_state != S_IDLE);

endmodule
